// File: rtl/dds_pkg.sv
// Shared defaults and helpers for the DDS sine front end.
package dds_pkg;
   localparam int PHASE_W_DEF = 16;
   localparam int ADDR_W_DEF  = 6;
   localparam int WIDTH_DEF   = 8;

   typedef logic [PHASE_W_DEF-1:0] phase_t;

   function automatic logic [ADDR_W_DEF-1:0] phase_to_addr(input phase_t phase);
      return phase[PHASE_W_DEF-1 -: ADDR_W_DEF];
   endfunction
endpackage

// File: rtl/dds_sine_gen_tick_gen.sv
// Sample-rate prescaler: one tick every DIV enabled clocks.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_presc;
   logic          w_wrap;

   assign w_wrap = (r_presc == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (clr) begin
         r_presc <= '0;
      end else if (en) begin
         r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      end
   end

   // A clear suppresses the tick so phase and output ignore that cycle.
   assign tick = en && !clr && w_wrap;
endmodule

// File: rtl/dds_sine_gen.sv
// DDS front end: phase accumulator driving an external sine ROM, with a
// registered valid/ready sample output and a sticky overrun flag.
module dds_sine_gen
   import dds_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = 64,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int DIV     = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               phase_clr,
   input  logic [PHASE_W-1:0] tune_word,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [WIDTH-1:0]   rom_data,
   output logic [WIDTH-1:0]   sample_data,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic               overrun
);
   logic [PHASE_W-1:0] r_phase;
   logic [WIDTH-1:0]   r_sample_data;
   logic               r_sample_valid;
   logic               r_overrun;
   logic               w_tick;
   logic               w_accept;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (phase_clr),
      .tick (w_tick)
   );

   generate
      if (PHASE_W == PHASE_W_DEF && ADDR_W == ADDR_W_DEF) begin : g_addr_def
         assign rom_addr = phase_to_addr(r_phase);
      end else begin : g_addr_gen
         assign rom_addr = r_phase[PHASE_W-1 -: ADDR_W];
      end
   endgenerate

   assign w_accept = r_sample_valid && sample_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
      end else if (phase_clr) begin
         r_phase <= '0;
      end else if (w_tick) begin
         r_phase <= r_phase + tune_word;
      end
   end

   // The sample is captured from the pre-increment address on the tick edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample_data  <= '0;
         r_sample_valid <= 1'b0;
      end else if (w_tick && (!r_sample_valid || w_accept)) begin
         r_sample_data  <= rom_data;
         r_sample_valid <= 1'b1;
      end else if (w_accept && !w_tick) begin
         r_sample_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (phase_clr) begin
         r_overrun <= 1'b0;
      end else if (w_tick && r_sample_valid && !w_accept) begin
         r_overrun <= 1'b1;
      end
   end

   assign sample_data  = r_sample_data;
   assign sample_valid = r_sample_valid;
   assign overrun      = r_overrun;
endmodule

// File: tb/tb_dds_sine_gen.sv
// Bench for dds_sine_gen: two instances (DIV=4 and DIV=1) with a stand-in
// combinational ROM; accepted samples are checked against a queue of expected values.
module tb_dds_sine_gen;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [7:0] lut(input int a);
      return 8'(((a % 64) * 37) + 11);
   endfunction

   // DIV=4 instance
   logic        a_rst, a_en, a_clr, a_ready;
   logic [15:0] a_tune;
   logic [5:0]  a_addr;
   logic [7:0]  a_rom_data, a_data;
   logic        a_valid, a_ovr;
   logic [7:0]  qa[$];

   assign a_rom_data = lut(int'(a_addr));

   dds_sine_gen #(.WIDTH(8), .DEPTH(64), .PHASE_W(16), .DIV(4)) dut (
      .clk(clk), .rst(a_rst), .en(a_en), .phase_clr(a_clr), .tune_word(a_tune),
      .rom_addr(a_addr), .rom_data(a_rom_data), .sample_data(a_data),
      .sample_valid(a_valid), .sample_ready(a_ready), .overrun(a_ovr)
   );

   // DIV=1 instance
   logic        b_rst, b_en, b_clr, b_ready;
   logic [15:0] b_tune;
   logic [5:0]  b_addr;
   logic [7:0]  b_rom_data, b_data;
   logic        b_valid, b_ovr;
   logic [7:0]  qb[$];

   assign b_rom_data = lut(int'(b_addr));

   dds_sine_gen #(.WIDTH(8), .DEPTH(64), .PHASE_W(16), .DIV(1)) dut1 (
      .clk(clk), .rst(b_rst), .en(b_en), .phase_clr(b_clr), .tune_word(b_tune),
      .rom_addr(b_addr), .rom_data(b_rom_data), .sample_data(b_data),
      .sample_valid(b_valid), .sample_ready(b_ready), .overrun(b_ovr)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitors: a handshake seen at the negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!a_rst && a_valid && a_ready) begin
         if (qa.size() == 0) chk("a_unexpected_sample", int'(a_data), -1);
         else chk("a_sample", int'(a_data), int'(qa.pop_front()));
      end
      if (!b_rst && b_valid && b_ready) begin
         if (qb.size() == 0) chk("b_unexpected_sample", int'(b_data), -1);
         else chk("b_sample", int'(b_data), int'(qb.pop_front()));
      end
   end

   initial begin
      a_rst = 1'b1; a_en = 1'b0; a_clr = 1'b0; a_ready = 1'b0; a_tune = 16'h0000;
      b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_ready = 1'b0; b_tune = 16'h0000;
      step(2);

      // reset state
      chk("rst_addr", int'(a_addr), 0);
      chk("rst_valid", int'(a_valid), 0);
      chk("rst_overrun", int'(a_ovr), 0);
      chk("rst_data", int'(a_data), 0);

      // basic stepping and 64-tick wrap
      a_rst = 1'b0; a_en = 1'b1; a_tune = 16'h0400; a_ready = 1'b1;
      step(3);
      chk("pre_tick_valid", int'(a_valid), 0);
      chk("pre_tick_addr", int'(a_addr), 0);
      qa.push_back(lut(0));
      step(1);
      chk("tick0_addr", int'(a_addr), 1);
      chk("tick0_valid", int'(a_valid), 1);
      for (int k = 1; k < 66; k++) begin
         qa.push_back(lut(k % 64));
         step(4);
         chk("walk_addr", int'(a_addr), (k + 1) % 64);
         chk("walk_valid", int'(a_valid), 1);
      end

      // negative tune from phase 0
      a_clr = 1'b1; a_tune = 16'hFC00;
      step(1);
      a_clr = 1'b0;
      chk("clr_addr", int'(a_addr), 0);
      qa.push_back(lut(0));
      step(4);
      chk("rev_addr0", int'(a_addr), 63);
      qa.push_back(lut(63));
      step(4);
      chk("rev_addr1", int'(a_addr), 62);

      // overrun with ready held low
      a_clr = 1'b1; a_tune = 16'h0400;
      step(1);
      a_clr = 1'b0; a_ready = 1'b0;
      qa.push_back(lut(0));
      step(4);
      chk("ovr_first_tick", int'(a_ovr), 0);
      chk("ovr_data0", int'(a_data), int'(lut(0)));
      step(4);
      chk("ovr_set", int'(a_ovr), 1);
      chk("ovr_data_hold", int'(a_data), int'(lut(0)));
      chk("ovr_addr", int'(a_addr), 2);
      a_ready = 1'b1;
      step(1);
      chk("drain_valid0", int'(a_valid), 0);
      step(1);
      chk("drain_valid1", int'(a_valid), 0);
      step(1);
      chk("drain_valid2", int'(a_valid), 0);
      qa.push_back(lut(2));
      step(1);
      chk("resume_valid", int'(a_valid), 1);
      chk("resume_data", int'(a_data), int'(lut(2)));
      chk("ovr_sticky", int'(a_ovr), 1);

      // phase_clr at address 10 with a pending sample
      for (int a = 3; a <= 9; a++) begin
         qa.push_back(lut(a));
         step(4);
      end
      chk("pre_clr_addr", int'(a_addr), 10);
      a_ready = 1'b0; a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      chk("pclr_addr", int'(a_addr), 0);
      chk("pclr_overrun", int'(a_ovr), 0);
      chk("pclr_valid", int'(a_valid), 1);
      chk("pclr_data", int'(a_data), int'(lut(9)));
      step(3);
      chk("pclr_no_early_tick", int'(a_addr), 0);
      a_ready = 1'b1;
      qa.push_back(lut(0));
      step(1);
      chk("pclr_tick_addr", int'(a_addr), 1);
      chk("coinc_valid", int'(a_valid), 1);
      chk("coinc_overrun", int'(a_ovr), 0);

      // mid-stream reset, then en=0 freeze
      a_ready = 1'b0; a_tune = 16'h9000;
      step(4);
      chk("mid_addr", int'(a_addr), 37);
      chk("mid_overrun", int'(a_ovr), 1);
      chk("mid_valid", int'(a_valid), 1);
      a_rst = 1'b1;
      step(1);
      a_rst = 1'b0; a_en = 1'b0; a_ready = 1'b1;
      qa.delete();
      chk("mrst_addr", int'(a_addr), 0);
      chk("mrst_valid", int'(a_valid), 0);
      chk("mrst_overrun", int'(a_ovr), 0);
      chk("mrst_data", int'(a_data), 0);
      step(10);
      chk("hold_addr", int'(a_addr), 0);
      chk("hold_valid", int'(a_valid), 0);
      a_en = 1'b1;
      step(3);
      chk("hold_presc_valid", int'(a_valid), 0);
      qa.push_back(lut(0));
      step(1);
      chk("hold_tick_valid", int'(a_valid), 1);
      chk("hold_tick_addr", int'(a_addr), 36);
      a_en = 1'b0;

      // DIV=1: tick and accept coincide every cycle
      b_rst = 1'b0; b_en = 1'b1; b_ready = 1'b1; b_tune = 16'h0400;
      for (int k = 0; k < 8; k++) begin
         qb.push_back(lut(k));
         step(1);
         chk("d1_addr", int'(b_addr), k + 1);
         chk("d1_valid", int'(b_valid), 1);
         chk("d1_overrun", int'(b_ovr), 0);
      end
      b_en = 1'b0;
      step(3);
      chk("d1_idle_valid", int'(b_valid), 0);

      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
